// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping stage: turns the divider's 10 Hz square wave into tenth-second
// ticks, runs start/stop/lap/clear control and keeps an MM:SS.t BCD count with lap freeze.
module stopwatch_core #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_10hz_in,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] d_tenths,
    output logic [3:0] d_sec_ones,
    output logic [3:0] d_sec_tens,
    output logic [3:0] d_min_ones,
    output logic [3:0] d_min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);
    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] MIN_TENS_MAX = DW'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_LAP     = 2'd3
    } state_e;

    typedef struct packed {
        logic [DW-1:0] min_tens;
        logic [DW-1:0] min_ones;
        logic [DW-1:0] sec_tens;
        logic [DW-1:0] sec_ones;
        logic [DW-1:0] tenths;
    } bcd_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   tick_c;

    state_e state_q, state_d;
    bcd_t   count_q, count_d;
    bcd_t   snap_q;
    bcd_t   disp_c;
    logic   rollover_q, rollover_d;
    logic   snap_en_c;
    logic   zero_c;
    logic   count_en_c;

    // Synchroniser chain plus edge flop; tick is the rising edge of the synced wave
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_10hz_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            snap_q     <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rollover_q <= rollover_d;
            if (snap_en_c) begin
                snap_q <= count_q;
            end
        end
    end

    // Control: clear beats start_stop beats lap; counting uses the pre-transition state
    always_comb begin
        state_d    = state_q;
        snap_en_c  = 1'b0;
        zero_c     = 1'b0;
        count_en_c = tick_c & ((state_q == S_RUNNING) | (state_q == S_LAP));
        case (state_q)
            S_IDLE: begin
                if (start_stop) begin
                    state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (start_stop) begin
                    state_d = S_PAUSED;
                end else if (lap) begin
                    state_d   = S_LAP;
                    snap_en_c = 1'b1;
                end
            end
            S_LAP: begin
                if (start_stop) begin
                    state_d = S_PAUSED;
                end else if (lap) begin
                    state_d = S_RUNNING;
                end
            end
            S_PAUSED: begin
                if (clear) begin
                    state_d = S_IDLE;
                    zero_c  = 1'b1;
                end else if (start_stop) begin
                    state_d = S_RUNNING;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BCD ripple increment with wrap at MAX_MIN_TENS 9:59.9
    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        if (zero_c) begin
            count_d = '0;
        end else if (count_en_c) begin
            if (count_q.tenths != 4'd9) begin
                count_d.tenths = count_q.tenths + 4'd1;
            end else begin
                count_d.tenths = '0;
                if (count_q.sec_ones != 4'd9) begin
                    count_d.sec_ones = count_q.sec_ones + 4'd1;
                end else begin
                    count_d.sec_ones = '0;
                    if (count_q.sec_tens != 4'd5) begin
                        count_d.sec_tens = count_q.sec_tens + 4'd1;
                    end else begin
                        count_d.sec_tens = '0;
                        if (count_q.min_ones != 4'd9) begin
                            count_d.min_ones = count_q.min_ones + 4'd1;
                        end else begin
                            count_d.min_ones = '0;
                            if (count_q.min_tens != MIN_TENS_MAX) begin
                                count_d.min_tens = count_q.min_tens + 4'd1;
                            end else begin
                                count_d.min_tens = '0;
                                rollover_d       = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign disp_c     = (state_q == S_LAP) ? snap_q : count_q;
    assign d_tenths   = disp_c.tenths;
    assign d_sec_ones = disp_c.sec_ones;
    assign d_sec_tens = disp_c.sec_tens;
    assign d_min_ones = disp_c.min_ones;
    assign d_min_tens = disp_c.min_tens;
    assign running    = (state_q == S_RUNNING) | (state_q == S_LAP);
    assign lap_active = (state_q == S_LAP);
    assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: randomized tick timing and button pulses against a tenths-count model.
module tb_stopwatch_core;
    localparam int unsigned S   = 2;
    localparam int unsigned MT1 = 5;
    localparam int unsigned MT2 = 0;

    logic clk;
    logic reset;
    logic tick_10hz_in;
    logic start_stop, lap, clear;
    logic start2, lap2, clear2;

    logic [3:0] a_t, a_so, a_st, a_mo, a_mt;
    logic       a_run, a_lap, a_roll;
    logic [3:0] b_t, b_so, b_st, b_mo, b_mt;
    logic       b_run, b_lap, b_roll;

    logic [22:0] obs1, obs2;
    assign obs1 = {a_mt, a_mo, a_st, a_so, a_t, a_run, a_lap, a_roll};
    assign obs2 = {b_mt, b_mo, b_st, b_so, b_t, b_run, b_lap, b_roll};

    stopwatch_core #(.SYNC_STAGES(S), .MAX_MIN_TENS(MT1)) dut (
        .clk(clk), .reset(reset), .tick_10hz_in(tick_10hz_in),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .d_tenths(a_t), .d_sec_ones(a_so), .d_sec_tens(a_st),
        .d_min_ones(a_mo), .d_min_tens(a_mt),
        .running(a_run), .lap_active(a_lap), .rollover(a_roll)
    );

    stopwatch_core #(.SYNC_STAGES(S), .MAX_MIN_TENS(MT2)) dut_short (
        .clk(clk), .reset(reset), .tick_10hz_in(tick_10hz_in),
        .start_stop(start2), .lap(lap2), .clear(clear2),
        .d_tenths(b_t), .d_sec_ones(b_so), .d_sec_tens(b_st),
        .d_min_ones(b_mo), .d_min_tens(b_mt),
        .running(b_run), .lap_active(b_lap), .rollover(b_roll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: count held as total tenths; states 0 idle, 1 running, 2 paused, 3 lap
    int   m_st[2];
    int   m_cnt[2];
    int   m_snap[2];
    bit   m_roll[2];
    logic m_h[0:S+1];

    function automatic int mod_of(int i);
        return (i == 0) ? (MT1 + 1) * 6000 : (MT2 + 1) * 6000;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_roll[i] = 1'b0;
        end
        for (int k = 0; k <= S + 1; k++) m_h[k] = 1'b0;
    endfunction

    function automatic void model_one(int i, bit ss, bit lp, bit cl, bit tick);
        int old;
        old = m_cnt[i];
        m_roll[i] = 1'b0;
        if (tick && (m_st[i] == 1 || m_st[i] == 3)) begin
            if (m_cnt[i] + 1 == mod_of(i)) begin
                m_cnt[i] = 0; m_roll[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        if (cl && m_st[i] == 2) begin
            m_st[i] = 0; m_cnt[i] = 0;
        end else if (ss) begin
            m_st[i] = (m_st[i] == 0 || m_st[i] == 2) ? 1 : 2;
        end else if (lp) begin
            if (m_st[i] == 1) begin m_st[i] = 3; m_snap[i] = old; end
            else if (m_st[i] == 3) m_st[i] = 1;
        end
    endfunction

    // A rising input edge sampled at clock edge n is counted at edge n+S
    function automatic void model_edge(bit ss, bit lp, bit cl, bit ss2, bit tk);
        bit tick;
        for (int k = S + 1; k > 0; k--) m_h[k] = m_h[k-1];
        m_h[0] = tk;
        tick = m_h[S] & ~m_h[S+1];
        model_one(0, ss, lp, cl, tick);
        model_one(1, ss2, 1'b0, 1'b0, tick);
    endfunction

    function automatic logic [22:0] exp_vec(int i);
        int v;
        logic [3:0] t, so, st, mo, mt;
        v  = (m_st[i] == 3) ? m_snap[i] : m_cnt[i];
        t  = 4'(v % 10);
        so = 4'((v / 10) % 10);
        st = 4'((v / 100) % 6);
        mo = 4'((v / 600) % 10);
        mt = 4'(v / 6000);
        return {mt, mo, st, so, t, (m_st[i] == 1 || m_st[i] == 3), (m_st[i] == 3), m_roll[i]};
    endfunction

    task automatic step(input bit ss, input bit lp, input bit cl, input bit ss2, input bit tk);
        @(negedge clk);
        start_stop = ss; lap = lp; clear = cl; start2 = ss2; tick_10hz_in = tk;
        @(posedge clk);
        if (!reset) model_edge(ss, lp, cl, ss2, tk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic edges(input int n, input bit fast);
        int hi, lo;
        for (int k = 0; k < n; k++) begin
            hi = fast ? 1 : int'($urandom_range(1, 3));
            lo = fast ? 1 : int'($urandom_range(1, 3));
            repeat (hi) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            repeat (lo) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(S + 2);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        start_stop = 0; lap = 0; clear = 0; start2 = 0; tick_10hz_in = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if (obs1 !== 23'h0 || obs2 !== 23'h0) begin
            errs++; $display("FAIL reset_state: got %h / %h, expected 0", obs1, obs2);
        end
        reset = 1'b0;
        idle(4);
        vecs++;
        if (obs1 !== exp_vec(0)) begin
            errs++; $display("FAIL idle_after_reset: got %h, expected %h", obs1, exp_vec(0));
        end
    endtask

    task automatic test_count();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (S - 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (a_t !== 4'd0) begin
            errs++; $display("FAIL tick_latency_early: got tenths %0d, expected 0", a_t);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (a_t !== 4'd1) begin
            errs++; $display("FAIL tick_latency: got tenths %0d, expected 1", a_t);
        end
        edges(24, 1'b0);
        vecs++;
        if (obs1 !== {20'h00025, 3'b100}) begin
            errs++; $display("FAIL count_25: got %h, expected %h", obs1, {20'h00025, 3'b100});
        end
    endtask

    task automatic test_minute_and_wrap();
        int rolls;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        edges(599, 1'b1);
        vecs++;
        if (obs1 !== {20'h00599, 3'b100}) begin
            errs++; $display("FAIL at_59_9: got %h, expected %h", obs1, {20'h00599, 3'b100});
        end
        edges(1, 1'b1);
        vecs++;
        if (obs1 !== {20'h01000, 3'b100}) begin
            errs++; $display("FAIL minute_carry: got %h, expected %h", obs1, {20'h01000, 3'b100});
        end
        edges(5399, 1'b1);
        vecs++;
        if (obs2 !== {20'h09599, 3'b100} || obs1 !== exp_vec(0)) begin
            errs++; $display("FAIL before_wrap: got %h / %h, expected %h / %h", obs2, obs1, {20'h09599, 3'b100}, exp_vec(0));
        end
        rolls = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < S + 3; k++) begin
            if (b_roll === 1'b1) rolls++;
            vecs++;
            if (obs2 !== exp_vec(1)) begin
                errs++; $display("FAIL wrap_cycle%0d: got %h, expected %h", k, obs2, exp_vec(1));
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        vecs++;
        if (rolls !== 1) begin
            errs++; $display("FAIL rollover_width: got %0d cycles, expected 1", rolls);
        end
        vecs++;
        if (obs1 !== {20'h10000, 3'b100} || obs2 !== {20'h00000, 3'b100}) begin
            errs++; $display("FAIL after_wrap: got %h / %h, expected %h / %h", obs1, obs2, {20'h10000, 3'b100}, {20'h00000, 3'b100});
        end
        edges(1, 1'b0);
        vecs++;
        if (obs2 !== {20'h00001, 3'b100}) begin
            errs++; $display("FAIL count_after_wrap: got %h, expected %h", obs2, {20'h00001, 3'b100});
        end
    endtask

    task automatic test_lap();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(42, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (obs1 !== {20'h00042, 3'b110}) begin
            errs++; $display("FAIL lap_enter: got %h, expected %h", obs1, {20'h00042, 3'b110});
        end
        edges(30, 1'b0);
        vecs++;
        if (obs1 !== {20'h00042, 3'b110} || obs1 !== exp_vec(0)) begin
            errs++; $display("FAIL lap_frozen: got %h, expected %h", obs1, {20'h00042, 3'b110});
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (obs1 !== {20'h00072, 3'b100}) begin
            errs++; $display("FAIL lap_release: got %h, expected %h", obs1, {20'h00072, 3'b100});
        end
    endtask

    task automatic test_clear();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(10, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(3, 1'b0);
        vecs++;
        if (obs1 !== {20'h00013, 3'b100}) begin
            errs++; $display("FAIL clear_ignored_running: got %h, expected %h", obs1, {20'h00013, 3'b100});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(5, 1'b0);
        vecs++;
        if (obs1 !== {20'h00013, 3'b000}) begin
            errs++; $display("FAIL paused_hold: got %h, expected %h", obs1, {20'h00013, 3'b000});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        edges(2, 1'b0);
        vecs++;
        if (obs1 !== 23'h0) begin
            errs++; $display("FAIL clear_to_idle: got %h, expected %h", obs1, 23'h0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (obs1 !== 23'h0) begin
            errs++; $display("FAIL clear_beats_start: got %h, expected %h", obs1, 23'h0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (S - 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (obs1 !== {20'h00004, 3'b000}) begin
            errs++; $display("FAIL stop_with_tick: got %h, expected %h", obs1, {20'h00004, 3'b000});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (obs1 !== {20'h00004, 3'b000}) begin
            errs++; $display("FAIL start_beats_lap: got %h, expected %h", obs1, {20'h00004, 3'b000});
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(337, 1'b1);
        vecs++;
        if (obs1 !== {20'h00337, 3'b100}) begin
            errs++; $display("FAIL at_33_7: got %h, expected %h", obs1, {20'h00337, 3'b100});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        vecs++;
        if (obs1 !== 23'h0 || obs2 !== 23'h0) begin
            errs++; $display("FAIL async_reset: got %h / %h, expected 0", obs1, obs2);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        vecs++;
        if (obs1 !== 23'h0) begin
            errs++; $display("FAIL no_count_after_reset: got %h, expected %h", obs1, 23'h0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(1, 1'b0);
        vecs++;
        if (obs1 !== {20'h00001, 3'b100}) begin
            errs++; $display("FAIL restart: got %h, expected %h", obs1, {20'h00001, 3'b100});
        end
    endtask

    task automatic test_random();
        bit ss, lp, cl, tk;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            ss = ($urandom % 12) == 0;
            lp = ($urandom % 8) == 0;
            cl = ($urandom % 10) == 0;
            tk = $urandom % 2;
            step(ss, lp, cl, 1'b0, tk);
            vecs++;
            if (obs1 !== exp_vec(0)) begin
                errs++; $display("FAIL random_cycle%0d: got %h, expected %h", n, obs1, exp_vec(0));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        tick_10hz_in = 0; start_stop = 0; lap = 0; clear = 0;
        start2 = 0; lap2 = 0; clear2 = 0;
        model_reset();
        test_reset();
        test_count();
        test_minute_and_wrap();
        test_lap();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timekeeping stage directly downstream of the clock divider.
- Takes the divider's 10 Hz square wave as a plain data input, synchronises it into the clk domain and turns each rising edge into a one-cycle tenth-of-second tick.
- Runs a start/stop/lap/clear state machine and keeps an MM:SS.t BCD count.
- Drives the display digits, selecting either the live count or a frozen lap snapshot.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tick_10hz_in (minimum 2).
- MAX_MIN_TENS, 5, highest value of the minutes-tens digit; the count wraps after MAX_MIN_TENS 9:59.9.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high.
- tick_10hz_in  in  1  10 Hz square wave from the divider; asynchronous to this block's logic.
- start_stop  in  1  one-cycle pulse, already debounced.
- lap  in  1  one-cycle pulse, already debounced.
- clear  in  1  one-cycle pulse, already debounced.
- d_tenths  out  4  BCD tenths digit, 0-9.
- d_sec_ones  out  4  BCD seconds-ones digit, 0-9.
- d_sec_tens  out  4  BCD seconds-tens digit, 0-5.
- d_min_ones  out  4  BCD minutes-ones digit, 0-9.
- d_min_tens  out  4  BCD minutes-tens digit, 0 to MAX_MIN_TENS.
- running  out  1  high in RUNNING or LAP.
- lap_active  out  1  high in LAP (display frozen).
- rollover  out  1  one-cycle pulse when the count wraps to zero.

Behaviour:
Reset:
- Reset is asynchronous and active-high; clock is clk.
- On reset: state IDLE; all live digits and snapshot digits 0; synchroniser and edge flops 0; all outputs 0.

Tick generation:
- tick_10hz_in passes through SYNC_STAGES flops; an edge flop holds the previous synchronised value.
- tick = synced & ~prev (one clk cycle wide).
- Latency from an input rising edge to tick is SYNC_STAGES+1 clk edges.
- A high input at reset release yields one tick; it is harmless because the state is IDLE.

States: IDLE, RUNNING, PAUSED, LAP.
- IDLE: start_stop -> RUNNING. lap and clear have no effect.
- RUNNING: start_stop -> PAUSED. lap -> LAP, and the snapshot captures the registered live count as it was before this edge. clear is ignored.
- LAP: start_stop -> PAUSED and the freeze is released. lap -> RUNNING and the freeze is released. clear is ignored.
- PAUSED: start_stop -> RUNNING. clear -> IDLE with live count zeroed. lap is ignored.
- Simultaneous pulses: priority is clear > start_stop > lap. A lower-priority pulse arriving in the same cycle as an accepted higher-priority pulse is dropped.

Counting:
- The live count increments on an edge where tick=1 and the current (pre-transition) state is RUNNING or LAP.
- A tick coinciding with start_stop in IDLE/PAUSED is not counted.
- A tick coinciding with start_stop in RUNNING is counted.
- BCD ripple: tenths 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens.
- Wrap: at MAX_MIN_TENS 9:59.9, a tick sets all digits to 0 and pulses rollover high for exactly one cycle (registered, same edge as the wrap). Counting continues.
- A clear accepted in PAUSED zeroes the count on the same edge.

Display:
- Digit outputs equal the snapshot while in LAP, otherwise the live count.
- Outputs are combinational selects of registers (no added latency).
- The snapshot is not cleared on leaving LAP; it is only overwritten by the next lap capture or by reset.

Reset mid-operation:
- Reset forces IDLE and zeros immediately, regardless of state or pending tick.

Test Plan:
1. Reset then start_stop, drive 25 input rising edges -> display 00:02.5, running=1; each tick lands SYNC_STAGES+1 cycles after its edge.
2. Count to 00:59.9 then one tick -> 01:00.0. Preload near wrap (default MAX_MIN_TENS=5) at 59:59.9 then one tick -> 00:00.0 with rollover high for exactly one cycle.
3. Running at 00:04.2, pulse lap -> lap_active=1 and display holds 00:04.2 while 30 more ticks arrive. Pulse lap again -> display 00:07.2, lap_active=0.
4. Running at 00:01.0, pulse clear -> ignored (count keeps advancing). Pulse start_stop -> PAUSED, ticks ignored. Pulse clear -> IDLE, 00:00.0.
5. In PAUSED, assert clear and start_stop in the same cycle -> IDLE, zero (clear wins). In RUNNING, start_stop coincident with tick -> count +1, then PAUSED.
6. Assert reset mid-run at 00:33.7, including while tick_10hz_in is high -> all outputs 0 asynchronously. After release, no counting until start_stop.
